// File: rtl/rf_1024x36_ctrl_if.sv
// Request/response bus between a requester and rf_1024x36_ctrl.
// Signal names match the controller's port list so bound checkers can use them directly.
interface rf_1024x36_ctrl_if;
   // Handshake: a request transfers on any clock edge where req_i & gnt_o are both 1.
   // gnt_o does not depend on req_i, so a requester may hold req_i while waiting.
   // Read responses are one-cycle rvalid_o pulses with no backpressure; rdata_o and
   // rerr_o are qualified by rvalid_o and hold their values in between.
   logic        req_i;
   logic        gnt_o;
   logic        we_i;
   logic [9:0]  addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        rerr_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o, rerr_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o, rerr_o
   );
endinterface

// File: rtl/rf_1024x36_ctrl.sv
// Controller for the 1024x36 byte-enabled register file macro: zero sweep after reset,
// registered macro ports, fixed-latency read return. Parity lanes enabled by RF1024_CTRL_PARITY_EN.
module rf_1024x36_ctrl #(
   parameter int RdLatency = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   rf_1024x36_ctrl_if.slave       bus,
   output logic                   init_done_o,
   output logic                   dbg_state_o,
   output logic                   rf_wen_o,
   output logic [9:0]             rf_awp_o,
   output logic [35:0]            rf_din_o,
   output logic [35:0]            rf_bwe_o,
   output logic                   rf_ren_o,
   output logic [9:0]             rf_arp_o,
   input  logic [35:0]            rf_dout_i
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [9:0]           r_cnt;
   logic [9:0]           w_cnt_next;
   logic                 w_gnt;
   logic                 w_init_wr;

   logic                 w_accept;
   logic                 w_wr;
   logic                 w_rd;
   logic [35:0]          w_lane_din;
   logic [35:0]          w_lane_bwe;

   logic                 r_init_done;
   logic                 r_wen;
   logic [9:0]           r_awp;
   logic [35:0]          r_din;
   logic [35:0]          r_bwe;
   logic                 r_ren;
   logic [9:0]           r_arp;

   logic [RdLatency-1:0] r_vpipe;
   logic [RdLatency-1:0] w_vpipe_next;
   logic                 r_rvalid;
   logic [31:0]          r_rdata;
   logic [31:0]          w_rdata;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_gnt        = 1'b0;
      w_init_wr    = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_wr  = 1'b1;
            w_cnt_next = r_cnt + 10'd1;
            if (r_cnt == 10'd1023) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_gnt = 1'b1;
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   assign dbg_state_o = r_state;
   assign bus.gnt_o   = w_gnt;

   // ---------------- request decode and lane expansion ----------------
   assign w_accept = bus.req_i & w_gnt;
   // A write with no byte enables is accepted but never reaches the macro.
   assign w_wr     = w_accept & bus.we_i & (|bus.be_i);
   assign w_rd     = w_accept & ~bus.we_i;

   always_comb begin
      w_lane_din = '0;
      w_lane_bwe = '0;
      for (int k = 0; k < 4; k++) begin
         w_lane_din[9*k +: 8] = bus.wdata_i[8*k +: 8];
`ifdef RF1024_CTRL_PARITY_EN
         w_lane_din[9*k+8]    = ^bus.wdata_i[8*k +: 8];
`endif
         w_lane_bwe[9*k +: 9] = {9{bus.be_i[k]}};
      end
   end

   // ---------------- macro port registers ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_init_done <= 1'b0;
         r_wen       <= 1'b0;
         r_awp       <= '0;
         r_din       <= '0;
         r_bwe       <= '0;
         r_ren       <= 1'b0;
         r_arp       <= '0;
      end else begin
         r_init_done <= (w_state_next == ST_RUN);
         r_wen       <= w_init_wr | w_wr;
         if (w_init_wr) begin
            r_awp <= r_cnt;
            r_din <= '0;
            r_bwe <= '1;
         end else if (w_wr) begin
            r_awp <= bus.addr_i;
            r_din <= w_lane_din;
            r_bwe <= w_lane_bwe;
         end
         r_ren <= w_rd;
         if (w_rd) begin
            r_arp <= bus.addr_i;
         end
      end
   end

   assign init_done_o = r_init_done;
   assign rf_wen_o    = r_wen;
   assign rf_awp_o    = r_awp;
   assign rf_din_o    = r_din;
   assign rf_bwe_o    = r_bwe;
   assign rf_ren_o    = r_ren;
   assign rf_arp_o    = r_arp;

   // ---------------- read return ----------------
   // Bit RdLatency-1 of the valid shift register is high in the cycle the macro data is valid.
   always_comb begin
      w_vpipe_next    = r_vpipe << 1;
      w_vpipe_next[0] = r_ren;
   end

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < 4; k++) begin
         w_rdata[8*k +: 8] = rf_dout_i[9*k +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_vpipe  <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_vpipe  <= w_vpipe_next;
         r_rvalid <= r_vpipe[RdLatency-1];
         if (r_vpipe[RdLatency-1]) begin
            r_rdata <= w_rdata;
         end
      end
   end

   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = r_rdata;

`ifdef RF1024_CTRL_PARITY_EN
   logic r_rerr;
   logic w_rerr;

   // Each 9-bit lane carries even parity, so any lane with odd popcount is corrupt.
   always_comb begin
      w_rerr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_rerr = w_rerr | (^rf_dout_i[9*k +: 9]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rerr <= 1'b0;
      end else if (r_vpipe[RdLatency-1]) begin
         r_rerr <= w_rerr;
      end
   end

   assign bus.rerr_o = r_rerr;
`else
   logic w_unused_par;

   assign w_unused_par = ^{rf_dout_i[35], rf_dout_i[26], rf_dout_i[17], rf_dout_i[8]};
   assign bus.rerr_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_1024x36_ctrl.sv
// Directed self-checking bench for rf_1024x36_ctrl with a behavioural 1024x36 macro model.
// Honours RF1024_CTRL_PARITY_EN for the parity-dependent expectations.
module tb_rf_1024x36_ctrl;

   localparam int RdLatency = 1;

`ifdef RF1024_CTRL_PARITY_EN
   localparam logic [35:0] DIN_DEADBEEF = {9'h0DE, 9'h1AD, 9'h0BE, 9'h1EF};
   localparam logic        FLIP_ERR     = 1'b1;
`else
   localparam logic [35:0] DIN_DEADBEEF = {9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF};
   localparam logic        FLIP_ERR     = 1'b0;
`endif
   localparam logic [35:0] DIN_11223344 = {9'h011, 9'h022, 9'h033, 9'h044};
   localparam logic [35:0] BWE_BE5      = 36'h0_07FC01FF;

   // ---------------- clock / reset ----------------
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- DUT ----------------
   rf_1024x36_ctrl_if bus ();
   logic        init_done_o;
   logic        dbg_state_o;
   logic        rf_wen_o;
   logic [9:0]  rf_awp_o;
   logic [35:0] rf_din_o;
   logic [35:0] rf_bwe_o;
   logic        rf_ren_o;
   logic [9:0]  rf_arp_o;
   logic [35:0] rf_dout_i;

   rf_1024x36_ctrl #(.RdLatency(RdLatency)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .bus         (bus),
      .init_done_o (init_done_o),
      .dbg_state_o (dbg_state_o),
      .rf_wen_o    (rf_wen_o),
      .rf_awp_o    (rf_awp_o),
      .rf_din_o    (rf_din_o),
      .rf_bwe_o    (rf_bwe_o),
      .rf_ren_o    (rf_ren_o),
      .rf_arp_o    (rf_arp_o),
      .rf_dout_i   (rf_dout_i)
   );

   // ---------------- macro model (starts with all-ones so the zero sweep is visible) ----------------
   logic [35:0] mem [1024] = '{default: '1};
   logic [35:0] dout_q = '1;
   logic        flip_par = 1'b0;

   always @(posedge clk_i) begin
      if (rf_wen_o) mem[rf_awp_o] <= (mem[rf_awp_o] & ~rf_bwe_o) | (rf_din_o & rf_bwe_o);
      if (rf_ren_o) dout_q <= mem[rf_arp_o];
   end

   assign rf_dout_i = dout_q ^ (flip_par ? 36'h1_00 : 36'h0);

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
      bus.req_i   = 1'b1;
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.wdata_i = wdata;
      bus.be_i    = be;
   endtask

   task automatic idle();
      bus.req_i = 1'b0;
   endtask

   // Called on the negedge of the first INIT cycle; returns on the negedge where
   // the macro port shows the sweep write to address n-1.
   task automatic sweep(input int n, output int bad);
      bad = 0;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk_i);
         if (rf_wen_o !== 1'b1 || rf_awp_o !== 10'(j - 1) ||
             rf_din_o !== 36'h0 || rf_bwe_o !== 36'hF_FFFF_FFFF) bad++;
         if (j < 1024 && (bus.gnt_o !== 1'b0 || init_done_o !== 1'b0)) bad++;
      end
   endtask

   logic [31:0] tbl [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};

   // ---------------- directed sequence ----------------
   initial begin
      int bad;
      int rv_cnt;

      bus.req_i   = 1'b1;
      bus.we_i    = 1'b0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.be_i    = '0;
      repeat (2) @(negedge clk_i);

      check("rst_gnt",       bus.gnt_o,    0);
      check("rst_rvalid",    bus.rvalid_o, 0);
      check("rst_rerr",      bus.rerr_o,   0);
      check("rst_rdata",     bus.rdata_o,  0);
      check("rst_init_done", init_done_o,  0);
      check("rst_wen",       rf_wen_o,     0);
      check("rst_ren",       rf_ren_o,     0);
      check("rst_awp",       rf_awp_o,     0);
      check("rst_arp",       rf_arp_o,     0);
      check("rst_din",       rf_din_o,     0);
      check("rst_bwe",       rf_bwe_o,     0);
      check("rst_state",     dbg_state_o,  0);

      // Sweep to address 500, then a one-cycle reset.
      rst_ni = 1'b1;
      sweep(501, bad);
      check("sweep_partial_bad", bad, 0);
      check("sweep_at_500",      rf_awp_o, 500);
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("midrst_wen",  rf_wen_o, 0);
      check("midrst_awp",  rf_awp_o, 0);
      check("midrst_gnt",  bus.gnt_o, 0);
      rst_ni = 1'b1;

      // Full sweep from address 0 with req_i held high.
      sweep(1024, bad);
      check("sweep_full_bad",  bad, 0);
      check("sweep_last_awp",  rf_awp_o, 1023);
      check("run_gnt",         bus.gnt_o, 1);
      check("run_init_done",   init_done_o, 1);
      check("run_state",       dbg_state_o, 1);
      check("sweep_no_rvalid", bus.rvalid_o, 0);
      idle();

      // Write 0xDEADBEEF to 5, read it back on the next cycle.
      @(negedge clk_i);
      drive(1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF);
      check("wr5_gnt", bus.gnt_o, 1);
      @(negedge clk_i);
      check("wr5_wen", rf_wen_o, 1);
      check("wr5_awp", rf_awp_o, 5);
      check("wr5_din", rf_din_o, DIN_DEADBEEF);
      check("wr5_bwe", rf_bwe_o, 36'hF_FFFF_FFFF);
      check("wr5_ren", rf_ren_o, 0);
      drive(1'b0, 10'd5, 32'h0, 4'h0);
      @(negedge clk_i);
      idle();
      check("rd5_ren", rf_ren_o, 1);
      check("rd5_arp", rf_arp_o, 5);
      check("rd5_wen", rf_wen_o, 0);
      @(negedge clk_i);
      check("rd5_rvalid_early", bus.rvalid_o, 0);
      @(negedge clk_i);
      check("rd5_rvalid", bus.rvalid_o, 1);
      check("rd5_rdata",  bus.rdata_o, 32'hDEAD_BEEF);
      check("rd5_rerr",   bus.rerr_o, 0);
      @(negedge clk_i);
      check("rd5_rvalid_pulse", bus.rvalid_o, 0);
      check("rd5_rdata_hold",   bus.rdata_o, 32'hDEAD_BEEF);

      // Partial write over a zeroed entry.
      drive(1'b1, 10'd7, 32'h1122_3344, 4'h5);
      @(negedge clk_i);
      check("wr7_wen", rf_wen_o, 1);
      check("wr7_bwe", rf_bwe_o, BWE_BE5);
      check("wr7_din", rf_din_o, DIN_11223344);
      drive(1'b0, 10'd7, 32'h0, 4'h0);
      @(negedge clk_i);
      idle();
      repeat (2) @(negedge clk_i);
      check("rd7_rvalid", bus.rvalid_o, 1);
      check("rd7_rdata",  bus.rdata_o, 32'h0022_0044);
      check("rd7_rerr",   bus.rerr_o, 0);

      // Write with no byte enables is granted but does not touch the macro.
      @(negedge clk_i);
      drive(1'b1, 10'd9, 32'hFFFF_FFFF, 4'h0);
      check("be0_gnt", bus.gnt_o, 1);
      @(negedge clk_i);
      check("be0_wen", rf_wen_o, 0);
      drive(1'b0, 10'd9, 32'h0, 4'h0);
      @(negedge clk_i);
      idle();
      repeat (2) @(negedge clk_i);
      check("rd9_rvalid", bus.rvalid_o, 1);
      check("rd9_rdata",  bus.rdata_o, 32'h0);
      @(negedge clk_i);

      // Four back-to-back writes then four back-to-back reads of addresses 0..3.
      for (int c = 0; c < 12; c++) begin
         check($sformatf("burst_rvalid_c%0d", c), bus.rvalid_o, (c >= 7 && c <= 10) ? 1 : 0);
         if (c >= 7 && c <= 10) begin
            check($sformatf("burst_rdata_c%0d", c), bus.rdata_o, tbl[c-7]);
            check($sformatf("burst_rerr_c%0d", c),  bus.rerr_o, 0);
         end
         if (c < 4)      drive(1'b1, 10'(c), tbl[c], 4'hF);
         else if (c < 8) drive(1'b0, 10'(c - 4), 32'h0, 4'h0);
         else            idle();
         @(negedge clk_i);
      end

      // Corrupt the lane-0 parity bit on the macro output.
      drive(1'b0, 10'd5, 32'h0, 4'h0);
      flip_par = 1'b1;
      @(negedge clk_i);
      idle();
      repeat (2) @(negedge clk_i);
      check("flip_rvalid", bus.rvalid_o, 1);
      check("flip_rdata",  bus.rdata_o, 32'hDEAD_BEEF);
      check("flip_rerr",   bus.rerr_o, FLIP_ERR);
      flip_par = 1'b0;
      @(negedge clk_i);
      check("flip_rvalid_pulse", bus.rvalid_o, 0);
      check("flip_rerr_hold",    bus.rerr_o, FLIP_ERR);

      // Reset with two reads in flight.
      drive(1'b0, 10'd0, 32'h0, 4'h0);
      @(negedge clk_i);
      drive(1'b0, 10'd1, 32'h0, 4'h0);
      @(negedge clk_i);
      idle();
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("inflight_rst_rvalid", bus.rvalid_o, 0);
      check("inflight_rst_ren",    rf_ren_o, 0);
      check("inflight_rst_gnt",    bus.gnt_o, 0);
      check("inflight_rst_done",   init_done_o, 0);
      check("inflight_rst_state",  dbg_state_o, 0);
      rst_ni = 1'b1;
      rv_cnt = 0;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk_i);
         if (bus.rvalid_o !== 1'b0) rv_cnt++;
         if (j == 1) begin
            check("restart_wen", rf_wen_o, 1);
            check("restart_awp", rf_awp_o, 0);
         end
         if (j == 2) check("restart_awp1", rf_awp_o, 1);
      end
      check("dropped_reads_rvalid", rv_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_1024x36_ctrl.md
# rf_1024x36_ctrl

Single-clock controller that fronts the 1024-entry × 36-bit byte-enabled register file macro. Accepts one 32-bit word request per cycle on a req/gnt port, expands each byte to a 9-bit lane (8 data + 1 parity), and drives the macro write and read ports from one registered stage. It returns read data with a fixed latency and a parity error flag. After reset it zero-initialises the whole array before granting any request.

## Interface
- RdLatency, 1: cycles from `rf_ren_o` high to `rf_dout_i` valid (legal 1..2).
- clk_i  in  1  clock; also drives the macro's read and write clock pins at the instantiation level.
- rst_ni  in  1  synchronous, active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle when `req_i & gnt_o`.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  10  word address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables, one bit per byte of `wdata_i`.
- rvalid_o  out  1  one-cycle pulse marking read data valid; no backpressure.
- rdata_o  out  32  read data.
- rerr_o  out  1  parity error on the returned word; qualified by `rvalid_o`.
- init_done_o  out  1  high once the initialisation sweep completes.
- rf_wen_o, rf_awp_o[9:0], rf_din_o[35:0], rf_bwe_o[35:0]  out  macro write port.
- rf_ren_o, rf_arp_o[9:0]  out  macro read port.
- rf_dout_i  in  36  macro read data.
- The macro's static pins (clock bypass, margin-control and fuse selects, supplies) are tied off at the instantiation level. This block does not drive them.

## Operation
- The FSM has two states, INIT and RUN. Reset enters INIT with the sweep counter at 0.
- INIT behaviour:
  - `gnt_o` is 0.
  - Each cycle the block writes all-zero data to address = counter, with all `rf_bwe_o` bits set, then increments the counter.
  - After address 1023 is written, the FSM moves to RUN and `init_done_o` is set.
  - The sweep takes 1024 cycles.
- RUN behaviour: `gnt_o` is 1 every cycle. Requests are accepted back-to-back with no bubbles.
- Lane mapping for k = 0..3:
  - `rf_din_o[9k+7:9k] = wdata_i[8k+7:8k]`.
  - `rf_din_o[9k+8]` = XOR of that byte (even parity).
  - `rf_bwe_o[9k+8:9k] = {9{be_i[k]}}`.
- Write with `be_i == 0`: the request is granted, but `rf_wen_o` stays 0 and no macro access occurs.
- Read: `rf_ren_o` is pulsed and the address is forwarded. The result is captured into `rdata_o` and `rerr_o`, which are registered.
- Read check: `rerr_o` = OR over the four lanes of (XOR of all 9 lane bits). `rdata_o` strips the parity bits.
- Reset values:
  - `gnt_o`, `rvalid_o`, `rerr_o`, `init_done_o`, `rf_wen_o`, `rf_ren_o` are 0.
  - `rdata_o`, `rf_awp_o`, `rf_arp_o`, `rf_din_o`, `rf_bwe_o` are 0.
- Reset mid-operation:
  - Reads already in the pipeline are dropped, and no `rvalid_o` is emitted for them.
  - The INIT sweep restarts from address 0.

## Timing
- A request accepted in cycle T drives the macro ports, from flops, in cycle T+1.
- Macro data is valid in cycle T+1+RdLatency.
- `rvalid_o`, `rdata_o` and `rerr_o` are valid in cycle T+2+RdLatency. With the default RdLatency this is T+3.
- Throughput is one request per cycle. Up to RdLatency+1 reads are in flight; a shift register of valid bits tracks them.
- Write-to-read ordering: a write accepted at T is visible to a read accepted at T+1 or later.
- Same-cycle read and write cannot occur, because only one request is accepted per cycle.
- `init_done_o` rises in the cycle after the write to address 1023 is issued.
- `rdata_o` and `rerr_o` hold their last values while `rvalid_o` is 0.

## Configuration
- Macro `RF1024_CTRL_PARITY_EN`.
- Defined: parity generation and checking as described above.
- Undefined:
  - Bits 9k+8 of `rf_din_o` are written as 0.
  - The lane check is removed.
  - `rerr_o` is tied to 0.
  - The data path, latency and INIT are unchanged.

## Test plan
- Reset, then hold `req_i` = 1 → `gnt_o` = 0 for 1024 cycles; `rf_awp_o` steps through 0..1023 with `rf_wen_o` = 1; `init_done_o` = 1 afterwards.
- Write 0xDEADBEEF to address 5 with `be_i` = 0xF, then read address 5 the next cycle → `rvalid_o` 3 cycles after the read grant; `rdata_o` = 0xDEADBEEF; `rerr_o` = 0.
- Write 0x11223344 to address 7 with `be_i` = 0x5 over the zero-initialised entry → read returns 0x00220044; `rf_bwe_o` = 0x0_07FC01FF during the write.
- Issue reads on 4 consecutive cycles to addresses 0..3 → 4 consecutive `rvalid_o` pulses, with data returned in order.
- Force `rf_dout_i[8]` to flip on a read (parity enabled) → `rerr_o` = 1 with `rvalid_o`. With the macro undefined → `rerr_o` = 0.
- Assert `rst_ni` = 0 for 1 cycle at sweep address 500, and separately with 2 reads in flight → the sweep restarts at 0, and no `rvalid_o` is produced for the dropped reads.
